// File: rtl/level_cost_accum_pkg.sv
// Shared encodings for the level cost accumulator: operating modes, FSM states
// and the internal accumulator width.
package level_cost_accum_pkg;

    typedef enum logic [1:0] {
        MODE_SQ   = 2'd0,
        MODE_ABS  = 2'd1,
        MODE_WSQ  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int ACC_W = 64;

endpackage

// File: rtl/level_cost_lane.sv
// Per-coefficient cost term: level^2, |level| or weight*level^2, always unsigned.
module level_cost_lane
    import level_cost_accum_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int W_WIDTH   = 8,
    parameter int TERM_W    = 2*BIT_WIDTH + W_WIDTH
) (
    input  logic [1:0]           mode,
    input  logic [BIT_WIDTH-1:0] level,
    input  logic [W_WIDTH-1:0]   weight,
    output logic [TERM_W-1:0]    term
);

    logic signed [BIT_WIDTH-1:0]   level_s;
    logic signed [2*BIT_WIDTH-1:0] sq_s;
    logic        [2*BIT_WIDTH-1:0] sq;
    logic        [BIT_WIDTH-1:0]   mag;

    // The most negative level squares to a positive value that still fits
    // in 2*BIT_WIDTH signed bits, and its magnitude fits BIT_WIDTH unsigned bits.
    assign level_s = $signed(level);
    assign sq_s    = level_s * level_s;
    assign sq      = $unsigned(sq_s);
    assign mag     = level_s[BIT_WIDTH-1] ? (~level + 1'b1) : level;

    always_comb begin
        term = TERM_W'(sq);
        case (mode)
            MODE_ABS: term = TERM_W'(mag);
            MODE_WSQ: term = TERM_W'(weight) * TERM_W'(sq);
            default:  term = TERM_W'(sq);
        endcase
    end

endmodule

// File: rtl/level_cost_accum.sv
// Level cost accumulator: walks NUM_BLOCKS blocks of COEFFS coefficients, one block
// per cycle, through a two-stage term/accumulate pipeline and reports a saturated sum.
module level_cost_accum
    import level_cost_accum_pkg::*;
#(
    parameter int BIT_WIDTH  = 16,
    parameter int COEFFS     = 16,
    parameter int NUM_BLOCKS = 8,
    parameter int W_WIDTH    = 8,
    parameter int SUM_WIDTH  = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [1:0]                           mode,
    input  logic [BIT_WIDTH*COEFFS*NUM_BLOCKS-1:0] levels,
    input  logic [W_WIDTH*COEFFS-1:0]            weights,
    output logic                                 busy,
    output logic                                 done,
    output logic [SUM_WIDTH-1:0]                 sum,
    output logic                                 ovf
);

    localparam int BLK_W  = BIT_WIDTH * COEFFS;
    localparam int TERM_W = 2*BIT_WIDTH + W_WIDTH;
    localparam int CNT_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(NUM_BLOCKS - 1);

    function automatic logic [SUM_WIDTH:0] sat_sum(input logic [ACC_W-1:0] a);
        if (|a[ACC_W-1:SUM_WIDTH])
            return {1'b1, {SUM_WIDTH{1'b1}}};
        return {1'b0, a[SUM_WIDTH-1:0]};
    endfunction

    state_e state_q, state_d;
    logic   accept, issue, finish, abort_job;

    logic [CNT_W-1:0]                        blk_q;
    logic [BIT_WIDTH*COEFFS*NUM_BLOCKS-1:0]  levels_p0;
    logic [W_WIDTH*COEFFS-1:0]               weights_p0;
    logic [1:0]                              mode_p0;
    logic [BLK_W-1:0]                        blk_lv;
    logic [TERM_W-1:0]                       lane_term [COEFFS];
    logic [TERM_W-1:0]                       term_p1   [COEFFS];
    logic                                    vld_p1;
    logic [ACC_W-1:0]                        lane_sum;
    logic [ACC_W-1:0]                        acc_p2;
    logic                                    done_q, ovf_q;
    logic [SUM_WIDTH-1:0]                    sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (abort)                  state_d = ST_IDLE;
                else if (blk_q == LAST_BLK) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = abort ? ST_IDLE : ST_DONE;
            ST_DONE:  state_d = start ? ST_RUN : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        accept    = start && !busy;
        abort_job = abort && busy;
        issue     = (state_q == ST_RUN) && !abort;
        finish    = (state_q == ST_DONE);
    end

    // Job capture and block sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            levels_p0  <= '0;
            weights_p0 <= '0;
            mode_p0    <= '0;
            blk_q      <= '0;
        end else begin
            if (accept) begin
                levels_p0  <= levels;
                weights_p0 <= weights;
                mode_p0    <= mode;
            end
            if (accept || abort_job)
                blk_q <= '0;
            else if (issue)
                blk_q <= (blk_q == LAST_BLK) ? '0 : blk_q + 1'b1;
        end
    end

    assign blk_lv = levels_p0[blk_q*BLK_W +: BLK_W];

    for (genvar j = 0; j < COEFFS; j++) begin : g_lane
        level_cost_lane #(
            .BIT_WIDTH (BIT_WIDTH),
            .W_WIDTH   (W_WIDTH),
            .TERM_W    (TERM_W)
        ) u_lane (
            .mode   (mode_p0),
            .level  (blk_lv[j*BIT_WIDTH +: BIT_WIDTH]),
            .weight (weights_p0[j*W_WIDTH +: W_WIDTH]),
            .term   (lane_term[j])
        );
    end

    // Stage 1: register per-lane terms
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            for (int j = 0; j < COEFFS; j++) term_p1[j] <= '0;
        end else begin
            vld_p1 <= issue;
            if (issue)
                for (int j = 0; j < COEFFS; j++) term_p1[j] <= lane_term[j];
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int j = 0; j < COEFFS; j++)
            lane_sum = lane_sum + ACC_W'(term_p1[j]);
    end

    // Stage 2: accumulate, then saturate into the result on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p2 <= '0;
            done_q <= 1'b0;
            sum_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (accept)
                acc_p2 <= '0;
            else if (vld_p1 && !abort_job)
                acc_p2 <= acc_p2 + lane_sum;
            done_q <= finish;
            if (finish)
                {ovf_q, sum_q} <= sat_sum(acc_p2);
        end
    end

    assign done = done_q;
    assign sum  = sum_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_level_cost_accum.sv
// Scoreboard bench for level_cost_accum: stimulus pushes expected results with
// their exact completion cycle; a monitor pops them whenever done is seen.
module tb_level_cost_accum;

    localparam int BW = 16, NC = 16, NB = 8, WW = 8, SW = 32;

    logic                  clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [1:0]            mode = 2'd0;
    logic [BW*NC*NB-1:0]   levels = '0;
    logic [WW*NC-1:0]      weights = '0;
    logic                  busy, done, ovf;
    logic [SW-1:0]         sum;

    level_cost_accum #(
        .BIT_WIDTH(BW), .COEFFS(NC), .NUM_BLOCKS(NB), .W_WIDTH(WW), .SUM_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .levels(levels), .weights(weights), .busy(busy), .done(done), .sum(sum), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] s; logic o; int at; } exp_t;
    exp_t sb[$];
    exp_t e_mon;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e_mon = sb.pop_front();
                check("sum", 64'(sum), 64'(e_mon.s));
                check("ovf", 64'(ovf), 64'(e_mon.o));
                check("done_cycle", 64'(cyc), 64'(e_mon.at));
            end
        end
    end

    task automatic set_uniform(input logic [15:0] v);
        for (int b = 0; b < NB; b++)
            for (int j = 0; j < NC; j++) levels[(b*NC+j)*BW +: BW] = v;
    endtask

    task automatic set_ramp_blocks();
        for (int b = 0; b < NB; b++)
            for (int j = 0; j < NC; j++) levels[(b*NC+j)*BW +: BW] = 16'(b + 1);
    endtask

    task automatic set_weights(input int w, input bool_lane);
        for (int j = 0; j < NC; j++) weights[j*WW +: WW] = bool_lane ? WW'(j) : WW'(w);
    endtask

    // Pulses start; T0 is the edge that samples it. Done is due after edge T0+10.
    task automatic start_job(input logic [1:0] m, input logic [31:0] es, input logic eo,
                             input logic expect_done, output int t0);
        @(posedge clk);
        #1 mode = m; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
        if (expect_done) sb.push_back('{es, eo, t0 + 10});
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk); #1; n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_job(input logic [1:0] m, input logic [31:0] es, input logic eo);
        int t0;
        start_job(m, es, eo, 1'b1, t0);
        wait_drain(30);
    endtask

    initial begin
        int t0, busy_cnt;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum",  64'(sum),  64'd0);
        check("rst_ovf",  64'(ovf),  64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // mode 0, all +1: 128, busy for 9 cycles
        set_uniform(16'sd1);
        start_job(2'd0, 32'd128, 1'b0, 1'b1, t0);
        busy_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 0) check("busy_after_start", 64'(busy), 64'd1);
            if (busy) busy_cnt++;
        end
        check("busy_cycles", 64'(busy_cnt), 64'd9);
        wait_drain(30);

        set_uniform(-16'sd3);
        run_job(2'd1, 32'd384, 1'b0);
        set_uniform(16'sd1);
        run_job(2'd3, 32'd128, 1'b0);
        set_uniform(16'sd2); set_weights(2, 1'b0);
        run_job(2'd2, 32'd1024, 1'b0);
        set_uniform(16'sd1); set_weights(0, 1'b1);
        run_job(2'd2, 32'd960, 1'b0);
        set_ramp_blocks();
        run_job(2'd1, 32'd576, 1'b0);
        run_job(2'd0, 32'd3264, 1'b0);
        set_uniform(16'h8000);
        run_job(2'd0, 32'hFFFF_FFFF, 1'b1);

        // levels change at T0+1 and a start at T0+3 must not disturb the job
        set_uniform(16'sd1);
        start_job(2'd0, 32'd128, 1'b0, 1'b1, t0);
        @(posedge clk); #1 set_uniform(16'sd5);
        @(posedge clk); #1 start = 1'b1; mode = 2'd1;
        @(posedge clk); #1 start = 1'b0;
        // back-to-back start sampled in the DONE cycle (edge T0+10)
        repeat (6) @(posedge clk);
        #1 start = 1'b1; mode = 2'd1; set_uniform(-16'sd3);
        @(negedge clk);
        check("busy_in_done", 64'(busy), 64'd0);
        @(posedge clk); #1 start = 1'b0;
        sb.push_back('{32'd384, 1'b0, t0 + 20});
        wait_drain(40);

        // abort at T0+4: busy drops, no done, result held
        set_uniform(16'sd1);
        start_job(2'd0, 32'd0, 1'b0, 1'b0, t0);
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        repeat (15) @(negedge clk);
        check("abort_sum_held", 64'(sum), 64'd384);
        check("abort_ovf_held", 64'(ovf), 64'd0);

        // reset at T0+5 clears everything, no done afterwards
        start_job(2'd0, 32'd0, 1'b0, 1'b0, t0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_sum",  64'(sum),  64'd0);
        check("midrst_ovf",  64'(ovf),  64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (15) @(negedge clk);

        run_job(2'd0, 32'd128, 1'b0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
